// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the instruction sequencer: field widths, opcodes,
// ALU select codes and the control FSM state type.
package instr_sequencer_pkg;

    localparam int ADDR_W = 5;
    localparam int OP_W   = 3;
    localparam int DATA_W = OP_W + ADDR_W;

    localparam logic [OP_W-1:0] OP_NOP = 3'd0;
    localparam logic [OP_W-1:0] OP_LDA = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD = 3'd2;
    localparam logic [OP_W-1:0] OP_SUB = 3'd3;
    localparam logic [OP_W-1:0] OP_STA = 3'd4;
    localparam logic [OP_W-1:0] OP_JMP = 3'd5;
    localparam logic [OP_W-1:0] OP_JZ  = 3'd6;
    localparam logic [OP_W-1:0] OP_HLT = 3'd7;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_t;

endpackage

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute control FSM driving the PC, the memory read/write port
// and the accumulator load strobe.
module instr_sequencer
    import instr_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_inc,
    output logic              jmp,
    output logic [ADDR_W-1:0] jmp_add,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              acc_zero,
    output logic              acc_ld,
    output logic [1:0]        alu_sel,
    output logic [DATA_W-1:0] ir,
    output logic              halted
);

    state_t              state, state_next;
    logic [DATA_W-1:0]   ir_next;
    logic                jump_q, jump_next;
    logic [OP_W-1:0]     opcode;
    logic [ADDR_W-1:0]   operand;

    assign opcode  = ir[DATA_W-1:ADDR_W];
    assign operand = ir[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            ir     <= '0;
            jump_q <= 1'b0;
        end else begin
            state  <= state_next;
            ir     <= ir_next;
            jump_q <= jump_next;
        end
    end

    // jump_q carries the DECODE-time branch decision (incl. sampled acc_zero)
    // into UPDATE, so UPDATE never looks at acc_zero itself.
    always_comb begin
        state_next = state;
        ir_next    = ir;
        jump_next  = jump_q;
        pc_inc     = 1'b0;
        jmp        = 1'b0;
        jmp_add    = '0;
        mem_addr   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        acc_ld     = 1'b0;
        alu_sel    = ALU_PASS;
        halted     = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end

            S_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = pc_addr;
                if (mem_ack) begin
                    ir_next    = mem_rdata;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                jump_next  = 1'b0;
                state_next = S_UPDATE;
                case (opcode)
                    OP_NOP: jump_next = 1'b0;
                    OP_JMP: jump_next = 1'b1;
                    OP_JZ:  jump_next = acc_zero;
                    OP_HLT: state_next = S_HALT;
                    default: state_next = S_EXEC;
                endcase
            end

            S_EXEC: begin
                mem_addr = operand;
                if (opcode == OP_STA) mem_wr = 1'b1;
                else                  mem_rd = 1'b1;
                if (mem_ack) begin
                    state_next = S_UPDATE;
                    if (opcode != OP_STA) begin
                        acc_ld = 1'b1;
                        case (opcode)
                            OP_ADD:  alu_sel = ALU_ADD;
                            OP_SUB:  alu_sel = ALU_SUB;
                            default: alu_sel = ALU_PASS;
                        endcase
                    end
                end
            end

            S_UPDATE: begin
                if (jump_q) begin
                    jmp     = 1'b1;
                    jmp_add = operand;
                end else begin
                    pc_inc  = 1'b1;
                end
                state_next = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: runs one small program through the sequencer with a PC and
// a wait-state memory model, checking every output cycle by cycle.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_inc, jmp, mem_rd, mem_wr, mem_ack;
    logic [ADDR_W-1:0] jmp_add, mem_addr;
    logic [DATA_W-1:0] mem_rdata, ir;
    logic              acc_zero, acc_ld, halted;
    logic [1:0]        alu_sel;

    logic [7:0] mem [32];
    logic [3:0] ws;
    logic [3:0] wcnt;
    logic       mem_stall;
    logic       ack_force;
    int         nvec = 0;
    int         nerr = 0;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .pc_addr(pc_addr),
        .pc_inc(pc_inc), .jmp(jmp), .jmp_add(jmp_add),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .acc_zero(acc_zero),
        .acc_ld(acc_ld), .alu_sel(alu_sel), .ir(ir), .halted(halted)
    );

    always #5 clk = ~clk;

    // Program counter model
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         pc_addr <= '0;
        else if (jmp)    pc_addr <= jmp_add;
        else if (pc_inc) pc_addr <= pc_addr + 5'd1;
    end

    // Memory model: ack after ws wait cycles, read data combinational
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                wcnt <= '0;
        else if ((mem_rd || mem_wr) && !mem_ack) wcnt <= wcnt + 4'd1;
        else                                    wcnt <= '0;
    end
    assign mem_ack   = ack_force || ((mem_rd || mem_wr) && !mem_stall && wcnt == ws);
    assign mem_rdata = mem[mem_addr];

    logic [25:0] obs;
    assign obs = {pc_inc, jmp, jmp_add, mem_addr, mem_rd, mem_wr, acc_ld, alu_sel, ir, halted};

    function automatic logic [25:0] pk(input logic inc, input logic j, input logic [4:0] ja,
                                       input logic [4:0] ma, input logic rd, input logic wr,
                                       input logic ld, input logic [1:0] alu,
                                       input logic [7:0] irv, input logic h);
        return {inc, j, ja, ma, rd, wr, ld, alu, irv, h};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if (obs !== 26'd0) begin
            nerr++;
            $display("FAIL reset_held: got %h expected %h", obs, 26'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== 26'd0) begin
                nerr++;
                $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs, 26'd0);
            end
        end
    endtask

    task automatic test_add();
        logic [25:0] e [4];
        e[0] = pk(0, 0, 0, 5'd0, 1, 0, 0, 2'b00, 8'h00, 0);
        e[1] = pk(0, 0, 0, 5'd0, 0, 0, 0, 2'b00, 8'h42, 0);
        e[2] = pk(0, 0, 0, 5'd2, 1, 0, 1, 2'b01, 8'h42, 0);
        e[3] = pk(1, 0, 0, 5'd0, 0, 0, 0, 2'b00, 8'h42, 0);
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run = 1'b0;
            nvec++;
            if (obs !== e[i]) begin
                nerr++;
                $display("FAIL add[%0d]: got %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_jmp();
        logic [25:0] e [3];
        e[0] = pk(0, 0, 0,     5'd1, 1, 0, 0, 2'b00, 8'h42, 0);
        e[1] = pk(0, 0, 0,     5'd0, 0, 0, 0, 2'b00, 8'hB7, 0);
        e[2] = pk(0, 1, 5'd23, 5'd0, 0, 0, 0, 2'b00, 8'hB7, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== e[i]) begin
                nerr++;
                $display("FAIL jmp[%0d]: got %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_jz();
        logic [25:0] e [6];
        e[0] = pk(0, 0, 0,    5'd23, 1, 0, 0, 2'b00, 8'hB7, 0);
        e[1] = pk(0, 0, 0,    5'd0,  0, 0, 0, 2'b00, 8'hC5, 0);
        e[2] = pk(0, 1, 5'd5, 5'd0,  0, 0, 0, 2'b00, 8'hC5, 0);
        e[3] = pk(0, 0, 0,    5'd5,  1, 0, 0, 2'b00, 8'hC5, 0);
        e[4] = pk(0, 0, 0,    5'd0,  0, 0, 0, 2'b00, 8'hC7, 0);
        e[5] = pk(1, 0, 0,    5'd0,  0, 0, 0, 2'b00, 8'hC7, 0);
        acc_zero = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== e[i]) begin
                nerr++;
                $display("FAIL jz[%0d]: got %h expected %h", i, obs, e[i]);
            end
            if (i == 3) acc_zero = 1'b0;
        end
    endtask

    task automatic test_sta_wait();
        logic [25:0] e [7];
        e[0] = pk(0, 0, 0, 5'd6, 1, 0, 0, 2'b00, 8'hC7, 0);
        e[1] = pk(0, 0, 0, 5'd0, 0, 0, 0, 2'b00, 8'h89, 0);
        e[2] = pk(0, 0, 0, 5'd9, 0, 1, 0, 2'b00, 8'h89, 0);
        e[3] = e[2];
        e[4] = e[2];
        e[5] = e[2];
        e[6] = pk(1, 0, 0, 5'd0, 0, 0, 0, 2'b00, 8'h89, 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== e[i]) begin
                nerr++;
                $display("FAIL sta_wait[%0d]: got %h expected %h", i, obs, e[i]);
            end
            if (i == 1) ws = 4'd3;
            if (i == 6) ws = 4'd0;
        end
    endtask

    task automatic test_lda_sub_nop();
        logic [25:0] e [12];
        e[0]  = pk(0, 0, 0, 5'd7,  1, 0, 0, 2'b00, 8'h89, 0);
        e[1]  = pk(0, 0, 0, 5'd0,  0, 0, 0, 2'b00, 8'h23, 0);
        e[2]  = pk(0, 0, 0, 5'd3,  1, 0, 1, 2'b00, 8'h23, 0);
        e[3]  = pk(1, 0, 0, 5'd0,  0, 0, 0, 2'b00, 8'h23, 0);
        e[4]  = pk(0, 0, 0, 5'd8,  1, 0, 0, 2'b00, 8'h23, 0);
        e[5]  = pk(0, 0, 0, 5'd0,  0, 0, 0, 2'b00, 8'h64, 0);
        e[6]  = pk(0, 0, 0, 5'd4,  1, 0, 1, 2'b10, 8'h64, 0);
        e[7]  = pk(1, 0, 0, 5'd0,  0, 0, 0, 2'b00, 8'h64, 0);
        e[8]  = pk(0, 0, 0, 5'd9,  1, 0, 0, 2'b00, 8'h64, 0);
        e[9]  = pk(0, 0, 0, 5'd0,  0, 0, 0, 2'b00, 8'h00, 0);
        e[10] = pk(1, 0, 0, 5'd0,  0, 0, 0, 2'b00, 8'h00, 0);
        e[11] = pk(0, 0, 0, 5'd10, 1, 0, 0, 2'b00, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== e[i]) begin
                nerr++;
                $display("FAIL lda_sub_nop[%0d]: got %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_halt();
        logic [25:0] e [5];
        e[0] = pk(0, 0, 0, 5'd0, 0, 0, 0, 2'b00, 8'hE0, 0);
        for (int i = 1; i < 5; i++) e[i] = pk(0, 0, 0, 5'd0, 0, 0, 0, 2'b00, 8'hE0, 1);
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== e[i]) begin
                nerr++;
                $display("FAIL halt[%0d]: got %h expected %h", i, obs, e[i]);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        logic [25:0] fe;
        fe = pk(0, 0, 0, 5'd0, 1, 0, 0, 2'b00, 8'h00, 0);
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (obs !== 26'd0) begin
            nerr++;
            $display("FAIL reset_from_halt: got %h expected %h", obs, 26'd0);
        end
        rst = 1'b0;
        mem_stall = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            run = 1'b0;
            nvec++;
            if (obs !== fe) begin
                nerr++;
                $display("FAIL fetch_wait[%0d]: got %h expected %h", i, obs, fe);
            end
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (obs !== 26'd0) begin
            nerr++;
            $display("FAIL async_drop: got %h expected %h", obs, 26'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_stall = 1'b0;
        ack_force = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== 26'd0) begin
                nerr++;
                $display("FAIL late_ack[%0d]: got %h expected %h", i, obs, 26'd0);
            end
        end
        ack_force = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        acc_zero = 1'b0;
        ws = 4'd0;
        mem_stall = 1'b0;
        ack_force = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]  = 8'h42;  // ADD 2
        mem[1]  = 8'hB7;  // JMP 23
        mem[23] = 8'hC5;  // JZ 5
        mem[5]  = 8'hC7;  // JZ 7
        mem[6]  = 8'h89;  // STA 9
        mem[7]  = 8'h23;  // LDA 3
        mem[8]  = 8'h64;  // SUB 4
        mem[9]  = 8'h00;  // NOP
        mem[10] = 8'hE0;  // HLT

        test_reset();
        test_add();
        test_jmp();
        test_jz();
        test_sta_wait();
        test_lda_sub_nop();
        test_halt();
        test_reset_mid_fetch();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
